// File: rtl/aes_inv_mix_columns_seq.sv
// Sequential AES InvMixColumns engine: one 32-bit column per cycle over valid/ready handshakes.
// Optional forward MixColumns select is enabled with `define AES_MIX_FWD_SEL_EN (adds modeInv port).
module aes_inv_mix_columns_seq #(
  parameter int COLS = 4
) (
`ifdef AES_MIX_FWD_SEL_EN
  input  logic         modeInv,
`endif
  input  logic         clk,
  input  logic         rstN,
  input  logic         inValid,
  output logic         inReady,
  input  logic [127:0] inData,
  output logic         outValid,
  input  logic         outReady,
  output logic [127:0] outData,
  output logic         busy
);

  if (COLS != 4) begin : gColsCheck
    $error("aes_inv_mix_columns_seq: COLS must be 4");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state;
  logic [127:0] stateReg;
  logic [1:0]   col;
  logic [31:0]  colIn;
  logic [31:0]  colOut;
  logic [7:0]   a0, a1, a2, a3;
`ifdef AES_MIX_FWD_SEL_EN
  logic         modeReg;
`endif

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] m09(input logic [7:0] b);
    return xt(xt(xt(b))) ^ b;
  endfunction

  function automatic logic [7:0] m0b(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(b) ^ b;
  endfunction

  function automatic logic [7:0] m0d(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(xt(b)) ^ b;
  endfunction

  function automatic logic [7:0] m0e(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(xt(b)) ^ xt(b);
  endfunction

  // Select the column currently being transformed; row 0 sits in the MSB byte.
  always_comb begin
    colIn = stateReg[127:96];
    case (col)
      2'd0: colIn = stateReg[127:96];
      2'd1: colIn = stateReg[95:64];
      2'd2: colIn = stateReg[63:32];
      2'd3: colIn = stateReg[31:0];
      default: colIn = stateReg[127:96];
    endcase
    a0 = colIn[31:24];
    a1 = colIn[23:16];
    a2 = colIn[15:8];
    a3 = colIn[7:0];
  end

  // Shared column datapath; the forward path only exists when the mode select is built in.
  always_comb begin
    colOut = {m0e(a0) ^ m0b(a1) ^ m0d(a2) ^ m09(a3),
              m0e(a1) ^ m0b(a2) ^ m0d(a3) ^ m09(a0),
              m0e(a2) ^ m0b(a3) ^ m0d(a0) ^ m09(a1),
              m0e(a3) ^ m0b(a0) ^ m0d(a1) ^ m09(a2)};
`ifdef AES_MIX_FWD_SEL_EN
    if (!modeReg) begin
      colOut = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                xt(a1) ^ xt(a2) ^ a2 ^ a3 ^ a0,
                xt(a2) ^ xt(a3) ^ a3 ^ a0 ^ a1,
                xt(a3) ^ xt(a0) ^ a0 ^ a1 ^ a2};
    end
`endif
  end

  assign outData = stateReg;

  // Control FSM with registered handshake outputs; columns are overwritten in place.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state    <= IDLE;
      stateReg <= '0;
      col      <= 2'd0;
      inReady  <= 1'b0;
      outValid <= 1'b0;
      busy     <= 1'b0;
`ifdef AES_MIX_FWD_SEL_EN
      modeReg  <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (inValid && inReady) begin
            stateReg <= inData;
            col      <= 2'd0;
            inReady  <= 1'b0;
            busy     <= 1'b1;
            state    <= CALC;
`ifdef AES_MIX_FWD_SEL_EN
            modeReg  <= modeInv;
`endif
          end else begin
            inReady <= 1'b1;
          end
        end
        CALC: begin
          case (col)
            2'd0: stateReg[127:96] <= colOut;
            2'd1: stateReg[95:64]  <= colOut;
            2'd2: stateReg[63:32]  <= colOut;
            2'd3: stateReg[31:0]   <= colOut;
            default: stateReg[127:96] <= colOut;
          endcase
          col <= col + 2'd1;
          if (col == 2'd3) begin
            outValid <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          if (outReady) begin
            outValid <= 1'b0;
            busy     <= 1'b0;
            inReady  <= 1'b1;
            state    <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
